// File: rtl/elevator_ctrl.sv
// elevator_ctrl: SCAN-order elevator scheduler with tick-timed travel and door dwell
module elevator_ctrl #(
  parameter int FLOORS     = 8,
  parameter int MOVE_TICKS = 3,
  parameter int DOOR_TICKS = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       tick,
  input  logic [7:0] btn_in,
  output logic [3:0] floor,
  output logic [7:0] floor_btn,
  output logic [3:0] countdown,
  output logic [3:0] status
);
  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;
  localparam logic [7:0] MASK = 8'((1 << FLOORS) - 1);
  localparam logic [3:0] MT = 4'(MOVE_TICKS);
  localparam logic [3:0] DT = 4'(DOOR_TICKS);
  state_t state, state_n;
  logic dir, dir_n;
  logic [3:0] floor_n, cnt_n, step;
  logic [7:0] req_n;
  logic above, below, here, ahead, behind, reload;
  assign above  = |(floor_btn >> (floor + 4'd1));
  assign below  = |(floor_btn & ((8'd1 << floor) - 8'd1));
  assign here   = floor_btn[floor[2:0]];
  assign ahead  = dir ? below : above;
  assign behind = dir ? above : below;
  assign reload = state == DOOR_OPEN && btn_in[floor[2:0]];
  assign step   = state == MOVE_UP ? floor + 4'd1 : floor - 4'd1;
  assign status = {2'b00, state};
  // dir: 0 = up, 1 = down
  always_comb begin
    state_n = state;
    dir_n   = dir;
    floor_n = floor;
    cnt_n   = countdown;
    if (state == IDLE) begin
      if (here) begin
        state_n = DOOR_OPEN;
        cnt_n   = DT;
      end else if (above || below) begin
        dir_n   = (above && below) ? dir : below;
        state_n = dir_n ? MOVE_DOWN : MOVE_UP;
        cnt_n   = MT;
      end
    end else if (state == DOOR_OPEN) begin
      if (reload) cnt_n = DT;
      else if (tick) begin
        if (countdown > 4'd1) cnt_n = countdown - 4'd1;
        else begin
          dir_n   = (!ahead && behind) ? ~dir : dir;
          state_n = (ahead || behind) ? (dir_n ? MOVE_DOWN : MOVE_UP) : IDLE;
          cnt_n   = (ahead || behind) ? MT : 4'd0;
        end
      end
    end else if (tick) begin
      if (countdown > 4'd1) cnt_n = countdown - 4'd1;
      else begin
        floor_n = step;
        state_n = floor_btn[step[2:0]] ? DOOR_OPEN : state;
        cnt_n   = floor_btn[step[2:0]] ? DT : MT;
      end
    end
    // Door entry or reload clears the door floor's request, beating a same-cycle press
    req_n = (floor_btn | (btn_in & MASK)) & ~(state_n == DOOR_OPEN ? 8'd1 << floor_n[2:0] : 8'd0);
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      dir       <= 1'b0;
      floor     <= '0;
      countdown <= '0;
      floor_btn <= '0;
    end else begin
      state     <= state_n;
      dir       <= dir_n;
      floor     <= floor_n;
      countdown <= cnt_n;
      floor_btn <= req_n;
    end
  end
endmodule

// File: tb/tb_elevator_ctrl.sv
// tb_elevator_ctrl: vector table, corner sequences and random traffic against a floor-list reference model
module tb_elevator_ctrl;
  localparam int NF = 8, MOVE = 3, DOOR = 5;
  logic CLK = 0, RST = 1, tick = 0;
  logic [7:0] btn_in = '0;
  logic [3:0] floor, countdown, status, floor6, countdown6, status6;
  logic [7:0] floor_btn, floor_btn6;
  int tests = 0, fails = 0;
  int m_floor, m_cnt, m_st, m_dir;
  bit m_req[NF];

  elevator_ctrl dut (.CLK(CLK), .RST(RST), .tick(tick), .btn_in(btn_in), .floor(floor),
                     .floor_btn(floor_btn), .countdown(countdown), .status(status));
  elevator_ctrl #(.FLOORS(6)) dut6 (.CLK(CLK), .RST(RST), .tick(tick), .btn_in(btn_in), .floor(floor6),
                     .floor_btn(floor_btn6), .countdown(countdown6), .status(status6));

  always #5 CLK = ~CLK;

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int m_btn();
    int v = 0;
    for (int i = 0; i < NF; i++) if (m_req[i]) v += 1 << i;
    return v;
  endfunction

  task automatic model_reset();
    m_floor = 0; m_cnt = 0; m_st = 0; m_dir = 1;
    for (int i = 0; i < NF; i++) m_req[i] = 0;
  endtask

  // Reference: counts pending floors on each side and applies the scheduling rules directly
  task automatic model_step(bit t, logic [7:0] b);
    int nf = m_floor, nc = m_cnt, ns = m_st, nd = m_dir, n_up = 0, n_dn = 0, fwd, rev;
    for (int i = 0; i < NF; i++) if (m_req[i]) begin
      if (i > m_floor) n_up++;
      if (i < m_floor) n_dn++;
    end
    fwd = m_dir > 0 ? n_up : n_dn;
    rev = m_dir > 0 ? n_dn : n_up;
    if (m_st == 0) begin
      if (m_req[m_floor]) begin ns = 3; nc = DOOR; end
      else if (n_up + n_dn > 0) begin
        if (n_up == 0 || n_dn == 0) nd = n_up > 0 ? 1 : -1;
        ns = nd > 0 ? 1 : 2; nc = MOVE;
      end
    end else if (m_st == 3) begin
      if (b[m_floor]) nc = DOOR;
      else if (t) begin
        if (m_cnt > 1) nc = m_cnt - 1;
        else if (fwd + rev == 0) begin ns = 0; nc = 0; end
        else begin
          if (fwd == 0) nd = -m_dir;
          ns = nd > 0 ? 1 : 2; nc = MOVE;
        end
      end
    end else if (t) begin
      if (m_cnt > 1) nc = m_cnt - 1;
      else begin
        nf = m_floor + (m_st == 1 ? 1 : -1);
        if (m_req[nf]) begin ns = 3; nc = DOOR; end
        else nc = MOVE;
      end
    end
    for (int i = 0; i < NF; i++) if (b[i]) m_req[i] = 1;
    if (ns == 3) m_req[nf] = 0;
    m_floor = nf; m_cnt = nc; m_st = ns; m_dir = nd;
  endtask

  task automatic check_model();
    chk("floor", int'(floor), m_floor);
    chk("floor_btn", int'(floor_btn), m_btn());
    chk("countdown", int'(countdown), m_cnt);
    chk("status", int'(status), m_st);
    chk("floor_in_range", int'(floor < NF), 1);
  endtask

  task automatic cyc(bit t, logic [7:0] b);
    tick = t; btn_in = b;
    @(posedge CLK);
    model_step(t, b);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    tick = 0; btn_in = '0; RST = 1;
    #1;
    model_reset();
    chk("rst_floor", int'(floor), 0);
    chk("rst_floor_btn", int'(floor_btn), 0);
    chk("rst_countdown", int'(countdown), 0);
    chk("rst_status", int'(status), 0);
    @(negedge CLK);
    RST = 0;
  endtask

  task automatic run_until(int st, string name);
    int n = 0;
    while (int'(status) != st && n < 200) begin cyc(1, 8'h00); n++; end
    chk(name, int'(status), st);
  endtask

  typedef struct {bit t; logic [7:0] b; int f, fb, c, s;} vec_t;
  vec_t tbl[$];

  initial begin
    model_reset();
    tbl.push_back('{0, 8'h08, 0, 8'h08, 0, 0});
    tbl.push_back('{0, 8'h00, 0, 8'h08, 3, 1});
    tbl.push_back('{1, 8'h00, 0, 8'h08, 2, 1});
    tbl.push_back('{0, 8'h00, 0, 8'h08, 2, 1});
    tbl.push_back('{1, 8'h00, 0, 8'h08, 1, 1});
    tbl.push_back('{1, 8'h00, 1, 8'h08, 3, 1});
    tbl.push_back('{1, 8'h00, 1, 8'h08, 2, 1});
    tbl.push_back('{1, 8'h00, 1, 8'h08, 1, 1});
    tbl.push_back('{1, 8'h00, 2, 8'h08, 3, 1});
    tbl.push_back('{1, 8'h00, 2, 8'h08, 2, 1});
    tbl.push_back('{1, 8'h00, 2, 8'h08, 1, 1});
    tbl.push_back('{1, 8'h00, 3, 8'h00, 5, 3});
    tbl.push_back('{1, 8'h00, 3, 8'h00, 4, 3});
    tbl.push_back('{1, 8'h00, 3, 8'h00, 3, 3});
    tbl.push_back('{1, 8'h00, 3, 8'h00, 2, 3});
    tbl.push_back('{1, 8'h00, 3, 8'h00, 1, 3});
    tbl.push_back('{1, 8'h00, 3, 8'h00, 0, 0});
    #2;
    do_reset();
    foreach (tbl[i]) begin
      cyc(tbl[i].t, tbl[i].b);
      chk($sformatf("vec%0d_floor", i), int'(floor), tbl[i].f);
      chk($sformatf("vec%0d_btn", i), int'(floor_btn), tbl[i].fb);
      chk($sformatf("vec%0d_cnt", i), int'(countdown), tbl[i].c);
      chk($sformatf("vec%0d_status", i), int'(status), tbl[i].s);
    end

    do_reset();
    cyc(0, 8'h08); cyc(0, 8'h00);
    repeat (7) cyc(1, 8'h00);
    chk("mid_floor", int'(floor), 2);
    chk("mid_cnt", int'(countdown), 2);
    chk("mid_status", int'(status), 1);
    do_reset();

    cyc(0, 8'h01); cyc(0, 8'h00);
    chk("cur_status", int'(status), 3);
    chk("cur_cnt", int'(countdown), 5);
    chk("cur_btn0", int'(floor_btn[0]), 0);
    repeat (3) cyc(1, 8'h00);
    chk("cur_cnt2", int'(countdown), 2);
    cyc(0, 8'h01);
    chk("reload_cnt", int'(countdown), 5);
    chk("reload_btn0", int'(floor_btn[0]), 0);
    repeat (4) cyc(1, 8'h00);
    cyc(1, 8'h01);
    chk("reload_vs_expire", int'(countdown), 5);
    chk("reload_vs_expire_st", int'(status), 3);
    run_until(0, "cur_idle");

    do_reset();
    cyc(0, 8'h40);
    for (int n = 0; n < 200 && floor != 4'd4; n++) cyc(1, 8'h00);
    chk("scan_at4", int'(floor), 4);
    cyc(1, 8'h02);
    run_until(3, "scan_door1");
    chk("scan_first_stop", int'(floor), 6);
    run_until(2, "scan_reverse");
    run_until(3, "scan_door2");
    chk("scan_second_stop", int'(floor), 1);

    do_reset();
    cyc(0, 8'h10);
    run_until(3, "tie_door");
    run_until(0, "tie_idle");
    chk("tie_floor", int'(floor), 4);
    cyc(0, 8'h44); cyc(0, 8'h00);
    chk("tie_break_up", int'(status), 1);

    do_reset();
    cyc(0, 8'hC0);
    chk("oor_floor_btn6", int'(floor_btn6), 0);
    do_reset();
    cyc(0, 8'h08); cyc(0, 8'h00);
    repeat (8) cyc(1, 8'h00);
    cyc(1, 8'h08);
    chk("arr_floor", int'(floor), 3);
    chk("arr_status", int'(status), 3);
    chk("arr_btn_clear", int'(floor_btn), 0);

    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (i % 1000 == 999) do_reset();
      cyc(1'($urandom_range(0, 1)),
          $urandom_range(0, 5) == 0 ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/elevator_ctrl.md
# elevator_ctrl

Elevator motion and request controller for the 8-floor elevator design. It latches floor-button requests, schedules travel in SCAN order (keep direction while requests remain ahead), and times floor-to-floor motion and door dwell with a per-tick countdown. Its `floor`, `floor_btn`, `countdown` and `status` outputs drive the `Display` block directly; `tick` comes from a `ClockDivider` instance.

## Interface
- `FLOORS`, 8: number of floors, 2..8; floors are numbered 0..FLOORS-1.
- `MOVE_TICKS`, 3: ticks spent travelling one floor, 1..15.
- `DOOR_TICKS`, 5: ticks the door stays open, 1..15.

- `CLK`  in  1: system clock; all state updates happen on its rising edge.
- `RST`  in  1: asynchronous, active-high reset.
- `tick`  in  1: one-CLK-wide timing enable from `ClockDivider`.
- `btn_in`  in  8: request buttons, one bit per floor, sampled as levels every CLK; bits >= FLOORS are ignored.
- `floor`  out  4: current floor.
- `floor_btn`  out  8: pending-request register.
- `countdown`  out  4: ticks remaining in the current move or door phase; 0 when idle.
- `status`  out  4: state code. 0 = IDLE, 1 = MOVE_UP, 2 = MOVE_DOWN, 3 = DOOR_OPEN; other codes are never driven.

## Operation
- Reset values: `floor` = 0, `floor_btn` = 0, `countdown` = 0, `status` = IDLE, internal direction `dir` = up.
- A reset asserted mid-operation aborts the current phase immediately and returns everything to the reset values.
- Request latch: `req <= (req | btn_in) & ~clr`.
  - `clr` is the current-floor bit on any cycle that enters or restarts DOOR_OPEN.
  - Clear wins over a simultaneous press of the same floor.
- Helper terms:
  - `above` = any `req` bit above `floor`.
  - `below` = any `req` bit below `floor`.
  - `here` = `req[floor]`.
- IDLE, evaluated every CLK with `tick` ignored:
  - If `here`: go to DOOR_OPEN, `countdown` = DOOR_TICKS, clear `req[floor]`.
  - Else if `above` and `below` are both set: move in `dir`.
  - Else if `above`: go to MOVE_UP, `dir` = up, `countdown` = MOVE_TICKS.
  - Else if `below`: go to MOVE_DOWN, `dir` = down, `countdown` = MOVE_TICKS.
- MOVE_UP and MOVE_DOWN, changing only on `tick`:
  - If `countdown` > 1: decrement.
  - If `countdown` == 1: `floor` steps by ±1. Then, if a request exists at the new floor, go to DOOR_OPEN (`countdown` = DOOR_TICKS, clear that bit). Otherwise stay in the same move state with `countdown` = MOVE_TICKS.
  - A move is entered only when a request lies ahead, and requests clear only at door opening. `floor` therefore never leaves 0..FLOORS-1; the bench asserts this.
- DOOR_OPEN:
  - Pressing the current floor's button (`btn_in[floor]` high on any CLK) reloads `countdown` = DOOR_TICKS; `req[floor]` stays clear.
  - On `tick` with `countdown` > 1: decrement.
  - On `tick` with `countdown` == 1:
    - If there are requests ahead in `dir`: continue in `dir`.
    - Else if there are requests in the opposite direction: reverse (`dir` flips) and start that move with `countdown` = MOVE_TICKS.
    - Else: go to IDLE with `countdown` = 0.
  - Precedence: a reload and an expiring tick in the same cycle resolve as reload (door stays open).
- Requests for floors other than the current one are accepted in every state.

## Timing
- A button press at edge N appears in `floor_btn` at N+1.
- From IDLE, a press at edge N changes `status` at edge N+2.
- All outputs are registered, so there is no combinational path from input to output.
- One floor of travel takes exactly MOVE_TICKS ticks. The door is open exactly DOOR_TICKS ticks unless reloaded.
- `countdown` changes only on `tick` edges or on a phase entry or reload.

## Test plan
- **Reset mid-travel:** assert RST while in MOVE_UP at floor 2 with `countdown` = 2 → the same cycle, `floor` = 0, `floor_btn` = 0, `countdown` = 0, `status` = 0.
- **Single request:** from reset, press floor 3 → `status` = 1.
  - `floor` advances 0→1→2→3, one step every 3 ticks.
  - At floor 3: `status` = 3, `countdown` = 5, `floor_btn[3]` = 0.
  - After 5 ticks: `status` = 0, `countdown` = 0.
- **Current-floor press:** at floor 0 idle, press `btn_in[0]` → DOOR_OPEN two edges later.
  - Pressing `btn_in[0]` again with `countdown` = 2 reloads `countdown` to 5.
  - `floor_btn[0]` stays 0 throughout.
- **SCAN order:** at floor 4 moving up with requests for 6 and 1 → door opens at 6 first, then `status` = 2 and `floor` walks down to 1, stopping nowhere else.
- **IDLE tie-break:** idle at floor 4 after an upward trip, press 2 and 6 in the same cycle → go to MOVE_UP (last `dir` = up).
- **Out-of-range and simultaneous press:** with FLOORS = 6, press `btn_in[7]` → `floor_btn` stays 0. A press of the arrival floor coincident with the door-open edge leaves that bit clear.
